// File: rtl/mesi_pkg.sv
// mesi_pkg: shared definitions for the cache command sequencer.
// Holds trace op codes, the MESI event codes emitted towards the per-line
// state machine, read/write flag encodings and the sequencer FSM states.
package mesi_pkg;

    // Trace op codes (cmd_op)
    localparam logic [3:0] OP_READ     = 4'd0;
    localparam logic [3:0] OP_WRITE    = 4'd1;
    localparam logic [3:0] OP_IFETCH   = 4'd2;
    localparam logic [3:0] OP_INVAL    = 4'd3;
    localparam logic [3:0] OP_SNOOP_RD = 4'd4;
    localparam logic [3:0] OP_CLEAR    = 4'd8;
    localparam logic [3:0] OP_PRINT    = 4'd9;

    // MESI event codes (ev_code)
    localparam logic [2:0] EV_CPU_READ    = 3'b000;
    localparam logic [2:0] EV_CPU_WRITE   = 3'b010;
    localparam logic [2:0] EV_SNOOP_READ  = 3'b101;
    localparam logic [2:0] EV_SNOOP_INVAL = 3'b110;
    localparam logic [2:0] EV_CLEAR       = 3'b111;

    // Read/write flag (ev_rw)
    localparam logic [1:0] RW_READ  = 2'd0;
    localparam logic [1:0] RW_WRITE = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        EMIT,
        CLEAR
    } state_t;

endpackage

// File: rtl/cache_cmd_sequencer_if.sv
// cache_cmd_sequencer_if: bundles the command input, event output, status
// and statistics signals of the sequencer.
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high; the sender holds valid and its payload stable until then,
// and the receiver may raise or drop ready freely.
//   slave  : sequencer side (consumes commands, produces events/status)
//   master : trace source / MESI stage side
interface cache_cmd_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 16,
    parameter int CNT_W  = 16
);
    import mesi_pkg::*;

    localparam int IDX_W = $clog2(SETS);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;

    logic              ev_valid;
    logic              ev_ready;
    logic [2:0]        ev_code;
    logic [1:0]        ev_rw;
    logic [IDX_W-1:0]  ev_set;
    logic              ev_hit;

    logic              busy;
    logic              err_op;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    state_t            dbg_state;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, ev_ready,
        output cmd_ready, ev_valid, ev_code, ev_rw, ev_set, ev_hit,
               busy, err_op, hit_cnt, miss_cnt, dbg_state
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, ev_ready,
        input  cmd_ready, ev_valid, ev_code, ev_rw, ev_set, ev_hit,
               busy, err_op, hit_cnt, miss_cnt, dbg_state
    );

endinterface

// File: rtl/cache_cmd_sequencer_fifo.sv
// cmd_fifo: synchronous FIFO with full/empty flags.
// Ports: clk, reset (sync, active-high), push_i/din_i write side,
// pop_i/dout_o read side (dout_o shows the head combinationally),
// full_o, empty_o. Push when full and pop when empty are ignored.
module cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/cache_cmd_sequencer.sv
// cache_cmd_sequencer: front end of the MESI cache model. Buffers trace
// commands, looks them up in a direct-mapped tag array and emits one MESI
// event per command; also runs the cache-clear sweep and hit/miss counters.
// Ports: clk, reset (sync, active-high), bus (slave modport) carrying
// cmd_* (command in), ev_* (event out), busy, err_op, hit_cnt, miss_cnt,
// dbg_state (current FSM state).
module cache_cmd_sequencer
    import mesi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int SETS       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_cmd_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int LA_W  = ADDR_W - OFFSET_W;  // line address width
    localparam int TAG_W = LA_W - IDX_W;
    localparam int FW    = 4 + LA_W;

    state_t            state_q, state_d;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_dout;
    logic [3:0]        op_q;
    logic [LA_W-1:0]   line_q;
    logic [TAG_W-1:0]  tag_arr_q [SETS];
    logic [SETS-1:0]   valid_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic [2:0]        ev_code_q, ev_code_d;
    logic [1:0]        ev_rw_q, ev_rw_d;
    logic [IDX_W-1:0]  ev_set_q;
    logic              ev_hit_q, err_q;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;
    logic [TAG_W-1:0]  cur_tag;
    logic [IDX_W-1:0]  cur_idx;
    logic              hit, is_cpu, alloc, inval, has_ev, bad_op, clr_last;
    logic              unused_offset_bits;

    // Only whole lines matter; the byte offset is never stored.
    assign unused_offset_bits = ^bus.cmd_addr[OFFSET_W-1:0];

    cmd_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.cmd_valid),
        .din_i   ({bus.cmd_op, bus.cmd_addr[ADDR_W-1:OFFSET_W]}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cur_tag  = line_q[LA_W-1:IDX_W];
    assign cur_idx  = line_q[IDX_W-1:0];
    assign hit      = valid_q[cur_idx] && (tag_arr_q[cur_idx] == cur_tag);
    assign clr_last = (clr_cnt_q == IDX_W'(SETS - 1));

    // Op decode for the command held in LOOKUP.
    always_comb begin
        is_cpu    = 1'b0;
        alloc     = 1'b0;
        inval     = 1'b0;
        has_ev    = 1'b1;
        bad_op    = 1'b0;
        ev_code_d = EV_CPU_READ;
        ev_rw_d   = RW_READ;
        case (op_q)
            OP_READ, OP_IFETCH: begin
                is_cpu = 1'b1;
                alloc  = !hit;
            end
            OP_WRITE: begin
                is_cpu    = 1'b1;
                alloc     = !hit;
                ev_code_d = EV_CPU_WRITE;
                ev_rw_d   = RW_WRITE;
            end
            OP_INVAL: begin
                ev_code_d = EV_SNOOP_INVAL;
                inval     = hit;
            end
            OP_SNOOP_RD: ev_code_d = EV_SNOOP_READ;
            OP_CLEAR, OP_PRINT: has_ev = 1'b0;
            default: begin
                has_ev = 1'b0;
                bad_op = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (has_ev)                 state_d = EMIT;
                else if (op_q == OP_CLEAR)  state_d = CLEAR;
                else                        state_d = IDLE;
            end
            EMIT:  if (bus.ev_ready) state_d = IDLE;
            CLEAR: if (clr_last)     state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            line_q     <= '0;
            valid_q    <= '0;
            clr_cnt_q  <= '0;
            ev_code_q  <= '0;
            ev_rw_q    <= '0;
            ev_set_q   <= '0;
            ev_hit_q   <= 1'b0;
            err_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            err_q <= (state_q == LOOKUP) && bad_op;
            if (fifo_pop) begin
                op_q   <= fifo_dout[FW-1 -: 4];
                line_q <= fifo_dout[LA_W-1:0];
            end
            if (state_q == LOOKUP) begin
                if (has_ev) begin
                    ev_code_q <= ev_code_d;
                    ev_rw_q   <= ev_rw_d;
                    ev_set_q  <= cur_idx;
                    ev_hit_q  <= hit;
                end
                if (alloc) valid_q[cur_idx] <= 1'b1;
                if (inval) valid_q[cur_idx] <= 1'b0;
                if (is_cpu) begin
                    if (hit && hit_cnt_q != '1)
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    if (!hit && miss_cnt_q != '1)
                        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
            end
            // Sweep one set per cycle; the counter wraps back to 0 on the
            // last set, ready for the next sweep.
            if (state_q == CLEAR) begin
                valid_q[clr_cnt_q] <= 1'b0;
                clr_cnt_q          <= clr_cnt_q + IDX_W'(1);
                if (clr_last) begin
                    ev_code_q <= EV_CLEAR;
                    ev_rw_q   <= RW_READ;
                    ev_set_q  <= '0;
                    ev_hit_q  <= 1'b0;
                end
            end
        end
    end

    // Tags need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && alloc) tag_arr_q[cur_idx] <= cur_tag;
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.ev_valid  = (state_q == EMIT);
    assign bus.ev_code   = ev_code_q;
    assign bus.ev_rw     = ev_rw_q;
    assign bus.ev_set    = ev_set_q;
    assign bus.ev_hit    = ev_hit_q;
    assign bus.busy      = (state_q == CLEAR);
    assign bus.err_op    = err_q;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Bench for cache_cmd_sequencer: directed steps followed by a random phase,
// with a cache reference model deciding every expected event and counter.
module tb_cache_cmd_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_cmd_sequencer_if #(.ADDR_W(32), .SETS(16), .CNT_W(16)) bus ();

    cache_cmd_sequencer #(
        .ADDR_W(32), .OFFSET_W(6), .SETS(16), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Expected events packed as {code[2:0], rw[1:0], set[3:0], hit}
    logic [9:0]  exp_q[$];
    bit          m_valid[16];
    logic [21:0] m_tag[16];
    int          exp_hit, exp_miss, exp_err, err_seen;
    int          ready_mode;   // 0 low, 1 high, 2 random
    logic [9:0]  mon_got;

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_err = 0; err_seen = 0;
    endfunction

    function automatic void model_apply(input logic [3:0] op, input logic [31:0] addr);
        int          idx;
        logic [21:0] tg;
        bit          hit;
        idx = int'((addr / 64) % 16);
        tg  = 22'(addr / 1024);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        case (op)
            4'd0, 4'd1, 4'd2: begin
                if (hit) exp_hit = (exp_hit < 65535) ? exp_hit + 1 : exp_hit;
                else     exp_miss = (exp_miss < 65535) ? exp_miss + 1 : exp_miss;
                exp_q.push_back({(op == 4'd1) ? 3'b010 : 3'b000,
                                 (op == 4'd1) ? 2'd1 : 2'd0, 4'(idx), hit});
                if (!hit) begin m_valid[idx] = 1'b1; m_tag[idx] = tg; end
            end
            4'd3: begin
                exp_q.push_back({3'b110, 2'd0, 4'(idx), hit});
                if (hit) m_valid[idx] = 1'b0;
            end
            4'd4: exp_q.push_back({3'b101, 2'd0, 4'(idx), hit});
            4'd8: begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                exp_q.push_back({3'b111, 2'd0, 4'd0, 1'b0});
            end
            4'd9: ;
            default: exp_err++;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command; returns one cycle after it is accepted.
    task automatic push(input logic [3:0] op, input logic [31:0] addr);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            @(posedge clk); #1;
            model_apply(op, addr);
        end
        bus.cmd_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_events", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_hit_cnt"},  32'(bus.hit_cnt),  32'(exp_hit));
        check({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 32'(exp_miss));
        check({tag, "_err_cnt"},  32'(err_seen),     32'(exp_err));
    endtask

    // ev_ready driver
    initial begin
        bus.ev_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.ev_ready = 1'b0;
                1:       bus.ev_ready = 1'b1;
                default: bus.ev_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Event monitor: every valid cycle must show the oldest expected event,
    // which also proves the fields hold steady under backpressure.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.ev_valid === 1'b1) begin
            mon_got = {bus.ev_code, bus.ev_rw, bus.ev_set, bus.ev_hit};
            tests_run++;
            assert (exp_q.size() != 0) else begin
                tests_failed++;
                $error("FAIL ev_unexpected: observed %0h expected none", mon_got);
            end
            if (exp_q.size() != 0) begin
                tests_run++;
                assert (mon_got === exp_q[0]) else begin
                    tests_failed++;
                    $error("FAIL ev_fields: observed %0h expected %0h", mon_got, exp_q[0]);
                end
                if (bus.ev_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
        if (reset === 1'b0 && bus.err_op === 1'b1) err_seen++;
    end

    initial begin
        int busy_cycles;
        logic [3:0] rop;
        logic [31:0] raddr;
        int r;

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_addr = '0;
        ready_mode = 1;
        model_reset();
        repeat (3) @(posedge clk); #1;

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_ev_valid",  32'(bus.ev_valid),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_err_op",    32'(bus.err_op),    32'd0);
        check("rst_hit_cnt",   32'(bus.hit_cnt),   32'd0);
        check("rst_miss_cnt",  32'(bus.miss_cnt),  32'd0);
        check("rst_ev_fields", 32'({bus.ev_code, bus.ev_rw, bus.ev_set, bus.ev_hit}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Read miss then hit on set 1
        push(4'd0, 32'h0000_1040);
        push(4'd0, 32'h0000_1040);
        drain();
        check("rd_hit_cnt",  32'(bus.hit_cnt),  32'd1);
        check("rd_miss_cnt", 32'(bus.miss_cnt), 32'd1);

        // Conflict eviction in set 1
        push(4'd1, 32'h0000_0040);
        push(4'd0, 32'h0000_0440);
        push(4'd1, 32'h0000_0040);
        drain();
        check_stats("conflict");

        // Backpressure: one in EMIT plus four buffered fills the FIFO
        ready_mode = 0;
        repeat (3) @(posedge clk); #1;
        push(4'd0, 32'h0000_1040);
        push(4'd1, 32'h0000_2080);
        push(4'd2, 32'h0000_30C0);
        push(4'd4, 32'h0000_1040);
        push(4'd3, 32'h0000_0040);
        @(negedge clk);
        check("bp_cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("bp_cmd_ready_hold", 32'(bus.cmd_ready), 32'd0);
        check("bp_ev_valid_hold",  32'(bus.ev_valid),  32'd1);
        @(posedge clk); #1;
        ready_mode = 1;
        drain();
        check_stats("bp");

        // Clear sweep
        for (int s = 0; s < 4; s++) push(4'd0, 32'h0000_1400 | (32'(s) << 6));
        drain();
        push(4'd8, 32'h0);
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cycles++;
        end
        check("clear_busy_cycles", 32'(busy_cycles), 32'd16);
        drain();
        for (int s = 0; s < 4; s++) push(4'd0, 32'h0000_1400 | (32'(s) << 6));
        drain();
        check_stats("clear");

        // Snoops
        push(4'd0, 32'h0000_2A80);
        push(4'd3, 32'h0000_2A80);
        push(4'd0, 32'h0000_2A80);
        push(4'd4, 32'h0000_7B00);
        push(4'd0, 32'h0000_7B00);
        drain();
        check_stats("snoop");

        // Undefined op and print
        push(4'd7, 32'h0000_0040);
        push(4'd9, 32'h0000_0040);
        drain();
        check("err_op_pulses", 32'(err_seen), 32'd1);

        // Random traffic with random backpressure
        ready_mode = 2;
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 19));
            if (r < 5)        rop = 4'd0;
            else if (r < 9)   rop = 4'd1;
            else if (r < 11)  rop = 4'd2;
            else if (r < 14)  rop = 4'd3;
            else if (r < 16)  rop = 4'd4;
            else if (r == 16) rop = 4'd9;
            else if (r == 17) rop = 4'd8;
            else if (r == 18) rop = 4'($urandom_range(10, 15));
            else              rop = 4'($urandom_range(5, 7));
            raddr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 6)
                    | $urandom_range(0, 63);
            push(rop, raddr);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        @(posedge clk); #1;
        ready_mode = 1;
        drain();
        check_stats("random");

        // Reset in the middle of a clear sweep with commands buffered
        for (int s = 0; s < 4; s++) push(4'd1, 32'h0000_0C00 | (32'(s) << 6));
        drain();
        push(4'd8, 32'h0);
        for (int i = 0; i < 10 && bus.busy !== 1'b1; i++) @(negedge clk);
        check("rstclr_busy_seen", 32'(bus.busy), 32'd1);
        repeat (3) @(negedge clk);
        push(4'd0, 32'h0000_0C00);
        push(4'd1, 32'h0000_0C40);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstclr_busy",      32'(bus.busy),      32'd0);
        check("rstclr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rstclr_ev_valid",  32'(bus.ev_valid),  32'd0);
        check("rstclr_hit_cnt",   32'(bus.hit_cnt),   32'd0);
        check("rstclr_miss_cnt",  32'(bus.miss_cnt),  32'd0);
        repeat (8) @(negedge clk);
        check("rstclr_fifo_empty", 32'(bus.ev_valid), 32'd0);
        @(posedge clk); #1;
        push(4'd0, 32'h0000_0C00);
        drain();
        check_stats("rstclr");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cache_cmd_sequencer.md
Name: cache_cmd_sequencer

Overview:
- Front-end stage directly upstream of the per-line MESI state machine in the cache simulator.
- Accepts trace commands (op code + address), buffers them, and performs a tag lookup in a direct-mapped tag array.
- Emits one MESI event per command (event code, read/write flag, set index, hit flag) over a valid/ready handshake.
- Also executes the cache-clear sweep and keeps hit/miss statistics.

Parameters:
- ADDR_W, 32, trace address width.
- OFFSET_W, 6, byte-offset bits (64-byte lines).
- SETS, 16, number of direct-mapped sets (power of 2); IDX_W = log2(SETS).
- FIFO_DEPTH, 4, command buffer entries (power of 2).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  trace command present.
- cmd_ready  out  1  FIFO not full; transfer when cmd_valid && cmd_ready.
- cmd_op  in  4  trace op: 0 read, 1 write, 2 ifetch, 3 snoop-invalidate, 4 snoop-read, 8 clear, 9 print.
- cmd_addr  in  ADDR_W  byte address.
- ev_valid  out  1  event to MESI stage valid.
- ev_ready  in  1  MESI stage accepts event.
- ev_code  out  3  event code (mesi_pkg).
- ev_rw  out  2  0 = read, 1 = write.
- ev_set  out  IDX_W  set index of the event.
- ev_hit  out  1  lookup hit.
- busy  out  1  clear sweep in progress.
- err_op  out  1  one-cycle pulse when an undefined op is dropped.
- hit_cnt  out  CNT_W  saturating CPU hit count.
- miss_cnt  out  CNT_W  saturating CPU miss count.

Behaviour:
- Reset (synchronous, active-high): FIFO empty; all tag valid bits 0; FSM IDLE; all outputs 0 except cmd_ready = 1.
- Reset mid-operation (during CLEAR or EMIT) discards all state identically.
- Address split: tag = addr[ADDR_W-1 : OFFSET_W+IDX_W]; idx = addr[OFFSET_W+IDX_W-1 : OFFSET_W].
- FIFO:
  - Push on cmd_valid && cmd_ready; cmd_ready = !full.
  - Push while full is impossible by the handshake.
  - Simultaneous push and pop when full is not allowed (ready is low); when empty, the pushed entry is popped the next cycle at the earliest.
  - Pointers wrap modulo FIFO_DEPTH.
- IDLE: if FIFO not empty, pop the head and go to LOOKUP.
- LOOKUP (1 cycle): hit = valid[idx] && tag_arr[idx] == tag. Action by op:
  - op 0/2: event EV_CPU_READ, rw = 0. On miss, write the tag and set valid.
  - op 1: event EV_CPU_WRITE, rw = 1. On miss, allocate as for reads.
  - op 3: event EV_SNOOP_INVAL, rw = 0. On hit, clear valid[idx].
  - op 4: event EV_SNOOP_READ, rw = 0. No array change.
  - op 8: go to CLEAR; no event.
  - op 9: no event; return to IDLE.
  - other ops: pulse err_op; return to IDLE.
  - Events 0–4 go to EMIT.
- EMIT: ev_valid = 1 with fields registered. Fields stay stable until ev_ready is sampled high, then return to IDLE.
- Latency: pop cycle T → ev_valid at T+2 when ev_ready is high (throughput 1 command per 3 cycles).
- CLEAR:
  - busy = 1; a counter walks set 0 to SETS-1, clearing one valid bit per cycle (SETS cycles).
  - Then emits a single EV_CLEAR with ev_set = 0 through EMIT.
  - FIFO pushes remain allowed during the sweep.
- Counters: ops 0/1/2 only. Increment hit_cnt or miss_cnt in LOOKUP; each saturates at all-ones (no wrap).
- Snoop ops never allocate lines.

Decomposition:
- Package mesi_pkg holds:
  - op constants (OP_READ = 0, OP_WRITE = 1, OP_IFETCH = 2, OP_INVAL = 3, OP_SNOOP_RD = 4, OP_CLEAR = 8, OP_PRINT = 9);
  - event codes (EV_CPU_READ = 3'b000, EV_CPU_WRITE = 3'b010, EV_SNOOP_READ = 3'b101, EV_SNOOP_INVAL = 3'b110, EV_CLEAR = 3'b111);
  - the FSM state enum (IDLE, LOOKUP, EMIT, CLEAR).
- One sub-module: cmd_fifo (parameterised synchronous FIFO with full/empty).

Test Plan:
- Read miss then hit: op 0 at 0x0000_1040, then op 0 at 0x0000_1040. Expect ev_hit = 0 then 1, ev_set = 1, ev_code = 000, miss_cnt = 1, hit_cnt = 1.
- Conflict eviction: op 1 at 0x0000_0040, then op 0 at 0x0000_0440 (same set 1). Expect both miss, ev_rw = 1 then 0; a third op 1 at 0x40 misses.
- Backpressure: hold ev_ready = 0 for 5 cycles with 5 commands queued. Expect cmd_ready = 0 after 4 pushes plus 1 in flight; ev fields stable; all 5 events emerge in order after release.
- Clear: fill sets 0–3, send op 8. Expect busy for 16 cycles, then EV_CLEAR; subsequent reads to the filled addresses miss.
- Snoop invalidate: op 3 at a resident address → ev_code = 110, ev_hit = 1; the next read there misses. Op 4 at an absent address → no allocation.
- Error and reset: op 7 → err_op pulses once, no ev_valid. Assert reset during the CLEAR sweep → busy = 0, FIFO empty, counters 0 on the next cycle.
